// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings for the alu_8bit execution stage.
// S[3:2] selects the operation group (arithmetic, logic, shift, misc);
// S[1:0] selects the operation within that group.
package alu_pkg;

  // Arithmetic group: (WIDTH+1)-bit sum, carry reported on Cout
  localparam logic [3:0] OP_TFR   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_DEC   = 4'b0011;

  // Logic group: Cout forced low
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOTA  = 4'b0111;

  // Shift group: Cout carries the bit shifted out
  localparam logic [3:0] OP_SHR   = 4'b1000;
  localparam logic [3:0] OP_SHL   = 4'b1001;
  localparam logic [3:0] OP_ROR   = 4'b1010;
  localparam logic [3:0] OP_ROL   = 4'b1011;

  // Misc group: Cout forced low
  localparam logic [3:0] OP_PASSB = 4'b1100;
  localparam logic [3:0] OP_NOR   = 4'b1101;
  localparam logic [3:0] OP_NAND  = 4'b1110;
  localparam logic [3:0] OP_XNOR  = 4'b1111;

endpackage

// File: rtl/alu_8bit_core.sv
// alu_8bit_core: purely combinational ALU datapath.
// Ports:
//   A, B      - operands (WIDTH bits)
//   Cin       - carry-in, also the fill bit for SHR/SHL
//   S         - 4-bit operation select (see alu_pkg)
//   next_D    - result to be registered
//   next_Cout - carry / shift-out flag to be registered
//   next_Z    - zero flag of next_D
module alu_8bit_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       S,
  output logic [WIDTH-1:0] next_D,
  output logic             next_Cout,
  output logic             next_Z
);

  logic [WIDTH-1:0] arith_opnd;
  logic [WIDTH:0]   sum;

  // Second adder operand for the arithmetic group; all four arithmetic ops
  // share a single A + opnd + Cin adder.
  always_comb begin
    arith_opnd = '0;
    case (S[1:0])
      2'b00:   arith_opnd = '0;
      2'b01:   arith_opnd = B;
      2'b10:   arith_opnd = ~B;
      default: arith_opnd = '1;
    endcase
  end

  assign sum = {1'b0, A} + {1'b0, arith_opnd} + {{WIDTH{1'b0}}, Cin};

  always_comb begin
    next_D    = '0;
    next_Cout = 1'b0;
    case (S)
      OP_TFR, OP_ADD, OP_SUB, OP_DEC: begin
        next_D    = sum[WIDTH-1:0];
        next_Cout = sum[WIDTH];
      end
      OP_AND:   next_D = A & B;
      OP_OR:    next_D = A | B;
      OP_XOR:   next_D = A ^ B;
      OP_NOTA:  next_D = ~A;
      OP_SHR: begin
        next_D    = {Cin, A[WIDTH-1:1]};
        next_Cout = A[0];
      end
      OP_SHL: begin
        next_D    = {A[WIDTH-2:0], Cin};
        next_Cout = A[WIDTH-1];
      end
      OP_ROR: begin
        next_D    = {A[0], A[WIDTH-1:1]};
        next_Cout = A[0];
      end
      OP_ROL: begin
        next_D    = {A[WIDTH-2:0], A[WIDTH-1]};
        next_Cout = A[WIDTH-1];
      end
      OP_PASSB: next_D = B;
      OP_NOR:   next_D = ~(A | B);
      OP_NAND:  next_D = ~(A & B);
      OP_XNOR:  next_D = ~(A ^ B);
      default: begin
        next_D    = '0;
        next_Cout = 1'b0;
      end
    endcase
  end

  // Z is taken from the value about to be registered so it always matches D
  assign next_Z = (next_D == '0);

endmodule

// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU (execution stage).
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset (D=0, Z=1, Cout=0)
//   A, B  - operands
//   Cin   - carry-in / shift fill bit
//   S     - operation select
//   D     - registered result (one cycle latency)
//   Z     - registered zero flag
//   Cout  - registered carry / shift-out flag
module alu_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       S,
  output logic [WIDTH-1:0] D,
  output logic             Z,
  output logic             Cout
);

  logic [WIDTH-1:0] next_D;
  logic             next_Cout;
  logic             next_Z;

  alu_8bit_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .S        (S),
    .next_D   (next_D),
    .next_Cout(next_Cout),
    .next_Z   (next_Z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D    <= '0;
      Z    <= 1'b1;
      Cout <= 1'b0;
    end else begin
      D    <= next_D;
      Z    <= next_Z;
      Cout <= next_Cout;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed-vector self-checking bench for alu_8bit.
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [3:0] S;
  logic [7:0] D;
  logic       Z;
  logic       Cout;

  int unsigned n_vec;
  int unsigned n_err;

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [3:0] s;
    logic [7:0] d;
    logic       cout;
  } vec_t;

  vec_t vecs[$];

  alu_8bit #(
    .WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .D    (D),
    .Z    (Z),
    .Cout (Cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [3:0] s);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    S   = s;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic cout);
    check({tag, ".D"}, D, d);
    check({tag, ".Cout"}, {7'd0, Cout}, {7'd0, cout});
    check({tag, ".Z"}, {7'd0, Z}, {7'd0, (d == 8'h00)});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //            tag       A      B      Cin   S        D      Cout
    vecs.push_back('{"tfr0",  8'h03, 8'h04, 1'b0, 4'b0000, 8'h03, 1'b0});
    vecs.push_back('{"tfr1",  8'h03, 8'h04, 1'b1, 4'b0000, 8'h04, 1'b0});
    vecs.push_back('{"add0",  8'h03, 8'h04, 1'b0, 4'b0001, 8'h07, 1'b0});
    vecs.push_back('{"add1",  8'h03, 8'h04, 1'b1, 4'b0001, 8'h08, 1'b0});
    vecs.push_back('{"sub0",  8'h03, 8'h04, 1'b0, 4'b0010, 8'hFE, 1'b0});
    vecs.push_back('{"sub1",  8'h03, 8'h04, 1'b1, 4'b0010, 8'hFF, 1'b0});
    vecs.push_back('{"subeq", 8'h05, 8'h05, 1'b1, 4'b0010, 8'h00, 1'b1});
    vecs.push_back('{"dec0",  8'h03, 8'h04, 1'b0, 4'b0011, 8'h02, 1'b1});
    vecs.push_back('{"dec1",  8'h03, 8'h04, 1'b1, 4'b0011, 8'h03, 1'b1});
    vecs.push_back('{"and",   8'h03, 8'h04, 1'b0, 4'b0100, 8'h00, 1'b0});
    vecs.push_back('{"or",    8'h03, 8'h04, 1'b0, 4'b0101, 8'h07, 1'b0});
    vecs.push_back('{"xor",   8'h03, 8'h04, 1'b0, 4'b0110, 8'h07, 1'b0});
    vecs.push_back('{"nota",  8'h03, 8'h04, 1'b0, 4'b0111, 8'hFC, 1'b0});
    vecs.push_back('{"rol03", 8'h03, 8'h04, 1'b0, 4'b1011, 8'h06, 1'b0});
    vecs.push_back('{"rol81", 8'h81, 8'h04, 1'b0, 4'b1011, 8'h03, 1'b1});
    vecs.push_back('{"shr81", 8'h81, 8'h04, 1'b1, 4'b1000, 8'hC0, 1'b1});
    vecs.push_back('{"shl81", 8'h81, 8'h04, 1'b0, 4'b1001, 8'h02, 1'b1});
    vecs.push_back('{"ror03", 8'h03, 8'h04, 1'b0, 4'b1010, 8'h81, 1'b1});
    vecs.push_back('{"passb", 8'h03, 8'h04, 1'b0, 4'b1100, 8'h04, 1'b0});
    vecs.push_back('{"nor",   8'h03, 8'h04, 1'b0, 4'b1101, 8'hF8, 1'b0});
    vecs.push_back('{"nand",  8'h03, 8'h04, 1'b0, 4'b1110, 8'hFF, 1'b0});
    vecs.push_back('{"xnor",  8'h03, 8'h04, 1'b0, 4'b1111, 8'hF8, 1'b0});

    // Reset held with live inputs: outputs stay at reset values across edges
    rst_n = 1'b0;
    A = 8'h03; B = 8'h04; Cin = 1'b0; S = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 8'h00, 1'b0);

    // Release: first edge after release captures 3 + 4
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("release", 8'h07, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s);
      @(posedge clk);
      #1;
      check_out(vecs[i].tag, vecs[i].d, vecs[i].cout);
    end

    // Latency: new inputs must not appear before the next edge
    drive(8'h03, 8'h04, 1'b0, 4'b0001);
    @(posedge clk);
    #1;
    check_out("lat_pre", 8'h07, 1'b0);
    drive(8'hFF, 8'h01, 1'b0, 4'b0001);
    #1;
    check_out("lat_hold", 8'h07, 1'b0);
    @(posedge clk);
    #1;
    check_out("lat_wrap", 8'h00, 1'b1);

    // Mid-stream async reset: outputs clear without a clock edge
    drive(8'h03, 8'h04, 1'b0, 4'b1010);
    @(posedge clk);
    #1;
    check_out("pre_rst", 8'h81, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_rst", 8'h81, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
